module_branch_predictor_gshare: RTL
===================================

Name: module_branch_predictor_gshare

Overview:
Parametrised next-generation fetch-stage branch predictor for the pipelined RV32I core. It combines a direct-mapped tagged BTB with a pattern history table (PHT) of 2-bit saturating counters. The PHT is indexed either bimodally or gshare-style, using a speculative global history register (GHR) that is repaired on mispredict. Lookup is combinational in Fetch; training arrives from Execute. Built-in performance counters report branch and mispredict totals.

Parameters:
XLEN, 32, address/data width
BTB_ENTRIES, 16, BTB depth; power of two, >=2
PHT_BITS, 6, log2 of PHT depth
GHR_BITS, 6, history length; 1..PHT_BITS
MODE, 1, 0 = bimodal (GHR forced 0), 1 = gshare
CNT_W, 32, width of statistics counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-low
pcf_i  in  XLEN  fetch PC
stallf_i  in  1  fetch stall; blocks speculative GHR shift
pred_hit_o  out  1  BTB valid and tag match for pcf_i
pred_taken_o  out  1  pred_hit_o & PHT counter MSB
pred_next_pc_o  out  XLEN  pred_taken_o ? BTB target : pcf_i+4
pred_ghr_o  out  GHR_BITS  GHR snapshot; piped to Execute with the instruction
upd_valid_i  in  1  Execute holds a conditional branch or jump (one per cycle)
upd_pc_i  in  XLEN  PC of resolving branch
upd_target_i  in  XLEN  resolved target
upd_taken_i  in  1  actual direction
upd_ghr_i  in  GHR_BITS  snapshot returned with the branch
upd_mispredict_i  in  1  actual direction or target differs from prediction (includes BTB-miss-but-taken)
stat_branches_o  out  CNT_W  count of updates
stat_mispredicts_o  out  CNT_W  count of mispredicts

Behaviour:
- Indexing:
  - BTB idx = pc[2 +: log2(BTB_ENTRIES)]; tag = pc[XLEN-1 : 2+log2(BTB_ENTRIES)].
  - PHT idx = pc[2 +: PHT_BITS] XOR zero-extended GHR (gshare), or pc[2 +: PHT_BITS] (bimodal).
  - Update uses upd_pc_i and upd_ghr_i in place of pcf_i and the GHR.
- Lookup: purely combinational, zero cycles. Reads see pre-edge state. There is no write-to-read bypass; a same-index same-cycle update becomes visible one cycle later.
- PHT update, when upd_valid_i: counter +1 if upd_taken_i, -1 otherwise. It saturates at 2'b11 and 2'b00.
- BTB update, when upd_valid_i & upd_taken_i: write valid=1, tag, and upd_target_i, replacing any conflicting entry. A not-taken update leaves the BTB untouched.
- GHR, with priority top-down:
  1. MODE=0: GHR is held at 0.
  2. upd_valid_i & upd_mispredict_i: GHR <= {upd_ghr_i[GHR_BITS-2:0], upd_taken_i}. For GHR_BITS=1, GHR <= upd_taken_i.
  3. !stallf_i & pred_hit_o: GHR <= {GHR[GHR_BITS-2:0], pred_taken_o}.
  4. Otherwise GHR holds.
- Counters: stat_branches_o +1 on upd_valid_i; stat_mispredicts_o +1 on upd_valid_i & upd_mispredict_i. Both wrap modulo 2^CNT_W.
- Reset (rst_i=0 at a rising edge):
  - All BTB valid bits = 0, all PHT counters = 2'b01 (weakly not-taken), GHR = 0, both stat counters = 0.
  - Reset overrides any simultaneous update.
  - Reset asserted mid-stream discards in-flight training.
  - After reset: pred_hit_o=0, pred_taken_o=0, pred_next_pc_o=pcf_i+4, pred_ghr_o=0.
- Arithmetic: pcf_i+4 is computed modulo 2^XLEN (0xFFFFFFFC -> 0x0).
- upd_* inputs are ignored when upd_valid_i=0.
- BTB storage has no reset beyond the valid bits.

Decomposition:
- Package bp_pkg:
  - typedef for the 2-bit counter, with constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - enum bp_mode_e {BP_BIMODAL, BP_GSHARE}.
  - function for the saturating next-state.
- Sub-module module_bp_pht: counter array, combinational read port, synchronous saturating write port.
- BTB, GHR and stat counters stay in the top module.

Test Plan:
- Reset, then pcf_i=0x100 -> pred_hit_o=0, pred_next_pc_o=0x104; stats 0.
- Train: upd pc=0x100, target=0x80, taken twice (PHT 01->10->11) -> pcf_i=0x100 gives hit=1, taken=1, next=0x80. Then two not-taken updates (11->10->01) -> taken=0, next=0x104 while hit stays 1.
- Saturation: 5 taken updates, counter stays 11; then one not-taken -> 10, so still predicts taken.
- Gshare aliasing, MODE=1, GHR_BITS=2: same PC trained taken under ghr=2'b01 and not-taken under ghr=2'b10 -> prediction follows the current GHR. Mispredict with upd_ghr_i=2'b01, taken=0 -> GHR=2'b10 next cycle, overriding a simultaneous speculative shift. With stallf_i=1, GHR is unchanged.
- Same-cycle lookup/update, same index -> the old prediction is seen that cycle and the new one the next cycle. A BTB tag conflict (0x100 vs 0x100+4*BTB_ENTRIES) evicts the older entry -> 0x100 misses.
- Counters with CNT_W=4: 17 updates, 3 mispredicts -> stat_branches_o=1 (wrapped), stat_mispredicts_o=3. Then rst_i low for one edge mid-update -> all zero and the update is lost.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare/bimodal branch predictor.
package bp_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t SNT = 2'b00;
  localparam ctr2_t WNT = 2'b01;
  localparam ctr2_t WT  = 2'b10;
  localparam ctr2_t ST  = 2'b11;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_e;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic ctr2_t ctr_next(input ctr2_t c, input logic taken);
    if (taken) begin
      return (c == ST) ? ST : ctr2_t'(c + 2'd1);
    end
    return (c == SNT) ? SNT : ctr2_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/module_bp_pht.sv
// Pattern history table: 2-bit counters, combinational read, saturating synchronous write.
module module_bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned PHT_BITS = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PHT_BITS-1:0] rd_idx,
  output ctr2_t               rd_ctr_c,
  input  logic                wr_en,
  input  logic [PHT_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int DEPTH = 1 << PHT_BITS;

  ctr2_t ctr_q [DEPTH];

  assign rd_ctr_c = ctr_q[rd_idx];

  // Reset wins over a same-edge training write.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= WNT;
      end
    end else if (wr_en) begin
      ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/module_branch_predictor_gshare.sv
// Fetch-stage predictor: tagged direct-mapped BTB plus PHT indexed bimodally or by
// PC xor speculative global history, trained from Execute, with branch statistics.
module module_branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned PHT_BITS    = 6,
  parameter int unsigned GHR_BITS    = 6,
  parameter int unsigned MODE        = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [XLEN-1:0]     pcf_i,
  input  logic                stallf_i,
  output logic                pred_hit_o,
  output logic                pred_taken_o,
  output logic [XLEN-1:0]     pred_next_pc_o,
  output logic [GHR_BITS-1:0] pred_ghr_o,
  input  logic                upd_valid_i,
  input  logic [XLEN-1:0]     upd_pc_i,
  input  logic [XLEN-1:0]     upd_target_i,
  input  logic                upd_taken_i,
  input  logic [GHR_BITS-1:0] upd_ghr_i,
  input  logic                upd_mispredict_i,
  output logic [CNT_W-1:0]    stat_branches_o,
  output logic [CNT_W-1:0]    stat_mispredicts_o
);

  localparam int unsigned BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W     = XLEN - 2 - BTB_IDX_W;
  localparam bit          GSHARE    = (MODE == 32'(BP_GSHARE));

  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_tgt_q [BTB_ENTRIES];

  logic [GHR_BITS-1:0]    ghr_q, ghr_d, ghr_repair, ghr_spec;
  logic [CNT_W-1:0]       br_cnt_q, mp_cnt_q;

  logic [BTB_IDX_W-1:0]   f_btb_idx, u_btb_idx;
  logic [TAG_W-1:0]       f_tag, u_tag;
  logic [PHT_BITS-1:0]    f_pht_idx, u_pht_idx;
  ctr2_t                  f_ctr;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pcf_i[1:0], upd_pc_i[1:0]};

  assign f_btb_idx = pcf_i[2 +: BTB_IDX_W];
  assign f_tag     = pcf_i[XLEN-1 -: TAG_W];
  assign u_btb_idx = upd_pc_i[2 +: BTB_IDX_W];
  assign u_tag     = upd_pc_i[XLEN-1 -: TAG_W];

  generate
    if (GSHARE) begin : g_gshare_idx
      assign f_pht_idx = pcf_i[2 +: PHT_BITS] ^ PHT_BITS'(ghr_q);
      assign u_pht_idx = upd_pc_i[2 +: PHT_BITS] ^ PHT_BITS'(upd_ghr_i);
    end else begin : g_bimodal_idx
      assign f_pht_idx = pcf_i[2 +: PHT_BITS];
      assign u_pht_idx = upd_pc_i[2 +: PHT_BITS];
    end

    if (GHR_BITS == 1) begin : g_ghr_one
      assign ghr_repair = upd_taken_i;
      assign ghr_spec   = pred_taken_o;
    end else begin : g_ghr_wide
      assign ghr_repair = {upd_ghr_i[GHR_BITS-2:0], upd_taken_i};
      assign ghr_spec   = {ghr_q[GHR_BITS-2:0], pred_taken_o};
    end
  endgenerate

  module_bp_pht #(
    .PHT_BITS (PHT_BITS)
  ) u_pht (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx   (f_pht_idx),
    .rd_ctr_c (f_ctr),
    .wr_en    (upd_valid_i),
    .wr_idx   (u_pht_idx),
    .wr_taken (upd_taken_i)
  );

  // Zero-cycle lookup against pre-edge state.
  assign pred_hit_o     = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);
  assign pred_taken_o   = pred_hit_o && f_ctr[1];
  assign pred_next_pc_o = pred_taken_o ? btb_tgt_q[f_btb_idx] : pcf_i + XLEN'(4);
  assign pred_ghr_o     = ghr_q;

  // Execute-side repair outranks the speculative fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (!GSHARE) begin
      ghr_d = '0;
    end else if (upd_valid_i && upd_mispredict_i) begin
      ghr_d = ghr_repair;
    end else if (!stallf_i && pred_hit_o) begin
      ghr_d = ghr_spec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      btb_valid_q <= '0;
    end else if (upd_valid_i && upd_taken_i) begin
      btb_valid_q[u_btb_idx] <= 1'b1;
    end
  end

  // Tag/target storage carries no reset; valid bits gate visibility.
  always_ff @(posedge clk_i) begin
    if (rst_i && upd_valid_i && upd_taken_i) begin
      btb_tag_q[u_btb_idx] <= u_tag;
      btb_tgt_q[u_btb_idx] <= upd_target_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else if (upd_valid_i) begin
      br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (upd_mispredict_i) begin
        mp_cnt_q <= mp_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stat_branches_o    = br_cnt_q;
  assign stat_mispredicts_o = mp_cnt_q;

endmodule
